// File: rtl/riscv_core_icache_axi_refill_if.sv
// rtl/riscv_core_icache_axi_refill_if.sv - AXI4 AR/R channel bundle between the icache refill master and memory
interface riscv_core_icache_axi_refill_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int BUS_WIDTH  = 64,
  parameter int ID_WIDTH   = 4
);
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic [ID_WIDTH-1:0]   arid;
  logic                  rvalid;
  logic                  rready;
  logic [BUS_WIDTH-1:0]  rdata;
  logic [1:0]            rresp;
  logic                  rlast;

  modport master (
    output arvalid, araddr, arlen, arsize, arburst, arid, rready,
    input  arready, rvalid, rdata, rresp, rlast
  );

  modport slave (
    input  arvalid, araddr, arlen, arsize, arburst, arid, rready,
    output arready, rvalid, rdata, rresp, rlast
  );
endinterface

// File: rtl/riscv_core_icache_axi_refill.sv
// rtl/riscv_core_icache_axi_refill.sv - AXI4 INCR-burst read master that assembles icache refill lines
module riscv_core_icache_axi_refill #(
  parameter int                  ADDR_WIDTH = 64,
  parameter int                  LINE_WIDTH = 256,
  parameter int                  BUS_WIDTH  = 64,
  parameter int                  ID_WIDTH   = 4,
  parameter logic [ID_WIDTH-1:0] ARID_VAL   = '0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_mem_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  o_mem_done,
  output logic [LINE_WIDTH-1:0] o_line_data,
  output logic                  o_bus_error,
  output logic                  o_busy,
  riscv_core_icache_axi_refill_if.master axi
);

  localparam int BEATS  = LINE_WIDTH / BUS_WIDTH;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFFSET = $clog2(LINE_WIDTH / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]            state;
  logic [CNT_W-1:0]      beat_cnt;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [LINE_WIDTH-1:0] line_q;
  logic                  is_last;
  logic                  unused_inputs;

  assign is_last = (beat_cnt == LAST_BEAT);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      beat_cnt <= '0;
      err_q    <= 1'b0;
      araddr_q <= '0;
      line_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // Line data is deliberately left alone here: the controller reads it after done.
          if (i_mem_req) begin
            araddr_q <= {i_addr[ADDR_WIDTH-1:OFFSET], {OFFSET{1'b0}}};
            err_q    <= 1'b0;
            beat_cnt <= '0;
            state    <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (axi.arready) state <= S_DATA;
        end
        S_DATA: begin
          if (axi.rvalid) begin
            line_q[int'(beat_cnt) * BUS_WIDTH +: BUS_WIDTH] <= axi.rdata;
            beat_cnt <= beat_cnt + 1'b1;
            // rlast is only cross-checked; the beat count alone ends the burst.
            if (axi.rresp[1] || (axi.rlast != is_last)) err_q <= 1'b1;
            if (is_last) state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign axi.arvalid = (state == S_ADDR);
  assign axi.araddr  = araddr_q;
  assign axi.arlen   = 8'(BEATS - 1);
  assign axi.arsize  = 3'($clog2(BUS_WIDTH / 8));
  assign axi.arburst = 2'b01;
  assign axi.arid    = ARID_VAL;
  assign axi.rready  = (state == S_DATA);

  assign o_mem_done  = (state == S_DONE);
  assign o_bus_error = (state == S_DONE) && err_q;
  assign o_busy      = (state != S_IDLE);
  assign o_line_data = line_q;

  assign unused_inputs = ^{i_addr[OFFSET-1:0], axi.rresp[0]};

endmodule

// File: tb/tb_riscv_core_icache_axi_refill.sv
// tb/tb_riscv_core_icache_axi_refill.sv - scoreboard bench for the icache AXI refill master
module tb_riscv_core_icache_axi_refill;

  logic         clk;
  logic         rst_n;
  logic         mem_req;
  logic [63:0]  addr_in;
  logic         mem_done;
  logic [255:0] line_data;
  logic         bus_error;
  logic         busy;

  int vectors;
  int miscompares;
  int done_cnt;
  int err_glitch;

  logic [63:0]  exp_addr_q[$];
  logic [255:0] exp_line_q[$];
  logic         exp_err_q[$];

  riscv_core_icache_axi_refill_if #(.ADDR_WIDTH(64), .BUS_WIDTH(64), .ID_WIDTH(4)) axi ();

  riscv_core_icache_axi_refill dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_mem_req   (mem_req),
    .i_addr      (addr_in),
    .o_mem_done  (mem_done),
    .o_line_data (line_data),
    .o_bus_error (bus_error),
    .o_busy      (busy),
    .axi         (axi)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (mem_done) done_cnt++;
    if (bus_error && !mem_done) err_glitch++;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  function automatic logic [7:0] beat_byte(input logic [7:0] base, input int k);
    return base + 8'(8'h11 * k);
  endfunction

  function automatic logic [255:0] mk_line(input logic [7:0] base);
    logic [255:0] l;
    for (int k = 0; k < 4; k++) l[k*64 +: 64] = {8{beat_byte(base, k)}};
    return l;
  endfunction

  // Drives one full refill; err_beat<0 means no SLVERR, last_beat is where rlast is raised.
  task automatic do_refill(input logic [63:0] addr, input logic [7:0] base, input int ar_delay,
                           input int r_gap, input int err_beat, input int last_beat,
                           input int exp_cycles);
    int           cycles;
    int           n;
    int           start_done;
    logic [63:0]  ad;
    logic [255:0] el;
    logic         ee;
    logic [255:0] held;

    exp_addr_q.push_back({addr[63:5], 5'b0});
    exp_line_q.push_back(mk_line(base));
    exp_err_q.push_back((err_beat >= 0) || (last_beat != 3));

    start_done   = done_cnt;
    mem_req      = 1'b1;
    addr_in      = addr;
    axi.arready  = (ar_delay == 0);
    cycles       = 0;

    @(negedge clk); cycles++;
    mem_req = 1'b0;
    addr_in = ~addr;
    ad = exp_addr_q.pop_front();
    vectors++;
    if (axi.arvalid !== 1'b1 || busy !== 1'b1 || axi.rready !== 1'b0) begin
      miscompares++;
      $display("FAIL addr_phase_entry: arvalid=%b busy=%b rready=%b, required 1 1 0",
               axi.arvalid, busy, axi.rready);
    end
    for (int i = 0; i < ar_delay; i++) begin
      vectors++;
      if (axi.arvalid !== 1'b1 || axi.araddr !== ad) begin
        miscompares++;
        $display("FAIL ar_stable: arvalid=%b araddr=%h, required 1 %h", axi.arvalid, axi.araddr, ad);
      end
      @(negedge clk); cycles++;
    end
    axi.arready = 1'b1;
    vectors++;
    if (axi.arvalid !== 1'b1 || axi.araddr !== ad || axi.arlen !== 8'd3 || axi.arsize !== 3'd3
        || axi.arburst !== 2'b01 || axi.arid !== 4'd0) begin
      miscompares++;
      $display("FAIL ar_handshake: arvalid=%b araddr=%h len=%0d size=%0d burst=%0d id=%0d, required 1 %h 3 3 1 0",
               axi.arvalid, axi.araddr, axi.arlen, axi.arsize, axi.arburst, axi.arid, ad);
    end
    @(negedge clk); cycles++;
    axi.arready = 1'b0;

    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < r_gap; g++) begin
        axi.rvalid = 1'b0;
        @(negedge clk); cycles++;
      end
      vectors++;
      if (axi.rready !== 1'b1 || mem_done !== 1'b0) begin
        miscompares++;
        $display("FAIL r_ready_beat%0d: rready=%b mem_done=%b, required 1 0", k, axi.rready, mem_done);
      end
      axi.rvalid = 1'b1;
      axi.rdata  = {8{beat_byte(base, k)}};
      axi.rresp  = (k == err_beat) ? 2'b10 : 2'b00;
      axi.rlast  = (k == last_beat);
      @(negedge clk); cycles++;
    end
    axi.rvalid = 1'b0;
    axi.rresp  = 2'b00;
    axi.rlast  = 1'b0;

    n = 0;
    while (mem_done !== 1'b1 && n < 20) begin
      @(negedge clk); cycles++; n++;
    end
    el = exp_line_q.pop_front();
    ee = exp_err_q.pop_front();
    vectors++;
    if (mem_done !== 1'b1) begin
      miscompares++;
      $display("FAIL done_timeout: mem_done=%b after %0d cycles, required 1", mem_done, cycles);
    end else begin
      if (exp_cycles >= 0) begin
        vectors++;
        if (cycles != exp_cycles) begin
          miscompares++;
          $display("FAIL done_latency: done at cycle %0d, required %0d", cycles, exp_cycles);
        end
      end
      vectors++;
      if (line_data !== el || bus_error !== ee) begin
        miscompares++;
        $display("FAIL line_result: line=%h err=%b, required %h %b", line_data, bus_error, el, ee);
      end
    end
    held = line_data;

    @(negedge clk);
    vectors++;
    if (mem_done !== 1'b0 || busy !== 1'b0 || line_data !== held || done_cnt - start_done != 1) begin
      miscompares++;
      $display("FAIL post_done: done=%b busy=%b pulses=%0d line=%h, required 0 0 1 %h",
               mem_done, busy, done_cnt - start_done, line_data, held);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_req = 1'b1;
    addr_in = 64'hdead_beef_0000_0040;
    repeat (3) @(negedge clk);
    vectors++;
    if (axi.arvalid !== 1'b0 || axi.rready !== 1'b0 || mem_done !== 1'b0 || bus_error !== 1'b0
        || busy !== 1'b0 || axi.araddr !== 64'd0 || line_data !== 256'd0) begin
      miscompares++;
      $display("FAIL reset_state: arvalid=%b rready=%b done=%b err=%b busy=%b araddr=%h line=%h, required all 0",
               axi.arvalid, axi.rready, mem_done, bus_error, busy, axi.araddr, line_data);
    end
    vectors++;
    if (axi.arlen !== 8'd3 || axi.arsize !== 3'd3 || axi.arburst !== 2'b01 || axi.arid !== 4'd0) begin
      miscompares++;
      $display("FAIL ar_constants: len=%0d size=%0d burst=%0d id=%0d, required 3 3 1 0",
               axi.arlen, axi.arsize, axi.arburst, axi.arid);
    end
    mem_req = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    do_refill(64'h0000_0000_8000_104A, 8'h11, 0, 0, -1, 3, 6);
  endtask

  task automatic test_stalls();
    do_refill(64'h0000_0000_8000_104A, 8'h11, 5, 2, -1, 3, -1);
  endtask

  task automatic test_error_resp();
    do_refill(64'h0000_0000_8000_2008, 8'h21, 0, 0, 2, 3, 6);
  endtask

  task automatic test_rlast_mismatch();
    do_refill(64'h0000_0000_8000_3010, 8'h31, 0, 1, -1, 1, -1);
  endtask

  task automatic test_back_to_back();
    logic [255:0] old;
    do_refill(64'h0000_0000_8000_1040, 8'h11, 0, 0, -1, 3, 6);
    old = mk_line(8'h11);
    @(negedge clk);
    vectors++;
    if (line_data !== old || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_hold: line=%h busy=%b, required %h 0", line_data, busy, old);
    end
    do_refill(64'h0000_0000_8000_1060, 8'h55, 0, 0, -1, 3, 6);
  endtask

  task automatic test_reset_mid_burst();
    mem_req = 1'b1;
    addr_in = 64'h0000_0000_8000_4000;
    axi.arready = 1'b1;
    @(negedge clk);
    mem_req = 1'b0;
    @(negedge clk);
    axi.arready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      axi.rvalid = 1'b1;
      axi.rdata  = {8{8'hA0 + 8'(k)}};
      @(negedge clk);
    end
    axi.rvalid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if (axi.arvalid !== 1'b0 || axi.rready !== 1'b0 || busy !== 1'b0 || mem_done !== 1'b0
        || line_data !== 256'd0) begin
      miscompares++;
      $display("FAIL mid_reset: arvalid=%b rready=%b busy=%b done=%b line=%h, required 0 0 0 0 0",
               axi.arvalid, axi.rready, busy, mem_done, line_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
    do_refill(64'h0000_0000_8000_5018, 8'h42, 0, 0, -1, 3, 6);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    done_cnt    = 0;
    err_glitch  = 0;
    rst_n       = 1'b0;
    mem_req     = 1'b0;
    addr_in     = '0;
    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    axi.rdata   = '0;
    axi.rresp   = 2'b00;
    axi.rlast   = 1'b0;

    test_reset();
    test_basic();
    test_stalls();
    test_error_resp();
    test_rlast_mismatch();
    test_back_to_back();
    test_reset_mid_burst();

    vectors++;
    if (err_glitch != 0) begin
      miscompares++;
      $display("FAIL bus_error_outside_done: %0d cycles, required 0", err_glitch);
    end
    vectors++;
    if (exp_addr_q.size() != 0 || exp_line_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d/%0d left, required 0/0", exp_addr_q.size(), exp_line_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
